// File: rtl/carlight_pkg.sv
// Shared types and default timing constants for the car-light mode selector and pattern stage.
package carlight_pkg;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,
        MODE_1 = 2'd1,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } light_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        PEND  = 2'd2
    } lms_state_t;

    localparam int DEF_TICK_DIV        = 1 << 22;
    localparam int DEF_DEBOUNCE_CYCLES = 1 << 20;

endpackage

// File: rtl/light_tick_gen.sv
// Pattern step tick (one pulse every TICK_DIV cycles) and blink phase that flips on each tick.
module light_tick_gen #(
    parameter int TICK_DIV = 8
) (
    input  logic clk,
    input  logic rstN,
    output logic tick,
    output logic blink
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] divCnt;
    logic          wrap;

    assign wrap = (divCnt == DIV_LAST);

    // tick and blink are registered off the wrap so they land on the edge divCnt returns to 0
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            divCnt <= '0;
            tick   <= 1'b0;
            blink  <= 1'b0;
        end else begin
            divCnt <= wrap ? '0 : divCnt + CW'(1);
            tick   <= wrap;
            blink  <= blink ^ wrap;
        end
    end

endmodule

// File: rtl/light_mode_sel.sv
// Synchronises and debounces the raw mode switches into a committed 2-bit mode, plus step tick/blink.
// Optional: define LIGHT_MODE_TICK_ALIGN_EN to defer mode commits to a tick cycle.
module light_mode_sel
    import carlight_pkg::*;
#(
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [1:0] swRaw,
    output logic [1:0] mode,
    output logic       modeChg,
    output logic       tick,
    output logic       blink,
    output lms_state_t dbgState
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]     swMeta;
    logic [1:0]     swSync;
    lms_state_t     state, stateNxt;
    light_mode_t    cand, candNxt;
    logic [DBW-1:0] dbCnt, dbCntNxt;
    logic [1:0]     modeNxt;
    logic           modeChgNxt;

    light_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) uTick (
        .clk  (clk),
        .rstN (rstN),
        .tick (tick),
        .blink(blink)
    );

    // swRaw goes straight into the first flop; nothing may sit in front of it
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            swMeta <= 2'b00;
            swSync <= 2'b00;
        end else begin
            swMeta <= swRaw;
            swSync <= swMeta;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= IDLE;
            cand    <= MODE_0;
            dbCnt   <= '0;
            mode    <= 2'b00;
            modeChg <= 1'b0;
        end else begin
            state   <= stateNxt;
            cand    <= candNxt;
            dbCnt   <= dbCntNxt;
            mode    <= modeNxt;
            modeChg <= modeChgNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        candNxt    = cand;
        dbCntNxt   = dbCnt;
        modeNxt    = mode;
        modeChgNxt = 1'b0;
        case (state)
            IDLE: begin
                if (swSync != mode) begin
                    stateNxt = CHECK;
                    candNxt  = light_mode_t'(swSync);
                    dbCntNxt = '0;
                end
            end
            CHECK: begin
                if (swSync == mode) begin
                    stateNxt = IDLE;
                end else if (swSync != cand) begin
                    candNxt  = light_mode_t'(swSync);
                    dbCntNxt = '0;
                end else if (dbCnt < DB_LAST) begin
                    dbCntNxt = dbCnt + DBW'(1);
                end else begin
`ifdef LIGHT_MODE_TICK_ALIGN_EN
                    if (tick) begin
                        modeNxt    = cand;
                        modeChgNxt = 1'b1;
                        stateNxt   = IDLE;
                    end else begin
                        stateNxt = PEND;
                    end
`else
                    modeNxt    = cand;
                    modeChgNxt = 1'b1;
                    stateNxt   = IDLE;
`endif
                end
            end
            PEND: begin
`ifdef LIGHT_MODE_TICK_ALIGN_EN
                // Debounce is done; wait for a step boundary unless the switch moves again
                if (swSync == mode) begin
                    stateNxt = IDLE;
                end else if (swSync != cand) begin
                    stateNxt = CHECK;
                    candNxt  = light_mode_t'(swSync);
                    dbCntNxt = '0;
                end else if (tick) begin
                    modeNxt    = cand;
                    modeChgNxt = 1'b1;
                    stateNxt   = IDLE;
                end
`else
                stateNxt = IDLE;
`endif
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign dbgState = state;

endmodule

// File: tb/tb_light_mode_sel.sv
// Self-checking bench for light_mode_sel (TICK_DIV=8, DEBOUNCE_CYCLES=4) against a run-length reference model.
module tb_light_mode_sel;
    import carlight_pkg::*;

    localparam int TDIV = 8;
    localparam int DB   = 4;

    logic       clk;
    logic       rstN;
    logic [1:0] swRaw;
    logic [1:0] mode;
    logic       modeChg;
    logic       tick;
    logic       blink;
    lms_state_t dbgState;

    int checks;
    int errors;
    int chgCount;

    // reference model: edges since reset, recent raw samples, committed mode and stable-run tracking
    int         mN;
    logic [1:0] histQ[$];
    logic [1:0] mMode;
    logic [1:0] runVal;
    int         runLen;
    logic       expChg;

    light_mode_sel #(
        .TICK_DIV       (TDIV),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .swRaw   (swRaw),
        .mode    (mode),
        .modeChg (modeChg),
        .tick    (tick),
        .blink   (blink),
        .dbgState(dbgState)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    task automatic modelReset();
        mN     = 0;
        histQ.delete();
        mMode  = 2'b00;
        runVal = 2'b00;
        runLen = 0;
        expChg = 1'b0;
    endtask

    // A new mode commits once the synchronised switch has shown the same non-current
    // value on DB+1 consecutive edges (and, when aligned, the edge sees a tick pulse).
    task automatic modelEdge();
        int         prevN;
        logic [1:0] s;
        logic       commitOk;
        prevN = mN;
        mN++;
        histQ.push_back(swRaw);
        if (histQ.size() > 3) void'(histQ.pop_front());
        s = (histQ.size() == 3) ? histQ[0] : 2'b00;
`ifdef LIGHT_MODE_TICK_ALIGN_EN
        commitOk = (prevN > 0) && (prevN % TDIV == 0);
`else
        commitOk = 1'b1;
`endif
        expChg = 1'b0;
        if (s == mMode) begin
            runLen = 0;
        end else begin
            if (runLen == 0 || s != runVal) begin
                runVal = s;
                runLen = 1;
            end else begin
                runLen++;
            end
            if (runLen >= DB + 1 && commitOk) begin
                mMode  = s;
                expChg = 1'b1;
                runLen = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h exp %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkOutputs();
        logic expTick;
        logic expBlink;
        expTick  = (mN > 0) && (mN % TDIV == 0);
        expBlink = ((mN / TDIV) % 2) == 1;
        chk("mode", mode, mMode);
        chk("modeChg", {1'b0, modeChg}, {1'b0, expChg});
        chk("tick", {1'b0, tick}, {1'b0, expTick});
        chk("blink", {1'b0, blink}, {1'b0, expBlink});
    endtask

    task automatic step();
        @(posedge clk);
        if (rstN) modelEdge();
        #1;
        if (modeChg === 1'b1) chgCount++;
        checkOutputs();
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases at the next falling edge
    task automatic pulseReset();
        #2;
        rstN = 1'b0;
        modelReset();
        #1;
        checkOutputs();
        chk("rst_state", dbgState, IDLE);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        chgCount = 0;
        rstN     = 1'b0;
        swRaw    = 2'b11;
        modelReset();

        // reset values with the switch already at 11, then a full debounce after release
        #2;
        checkOutputs();
        chk("rst_state", dbgState, IDLE);
        repeat (3) step();
        @(negedge clk);
        rstN = 1'b1;
        repeat (16) step();
        chk("t1_mode", mode, 2'b11);
        chk("t1_pulses", 2'(chgCount), 2'd1);

        // bounce 00/01 every two cycles never commits
        swRaw = 2'b00;
        pulseReset();
        repeat (4) step();
        chgCount = 0;
        for (int i = 0; i < 10; i++) begin
            swRaw = (i % 2 == 0) ? 2'b01 : 2'b00;
            repeat (2) step();
        end
        swRaw = 2'b00;
        repeat (8) step();
        chk("t2_mode", mode, 2'b00);
        chk("t2_pulses", 2'(chgCount), 2'd0);

        // clean 00 -> 10 change
        chgCount = 0;
        swRaw = 2'b10;
        repeat (16) step();
        chk("t3_mode", mode, 2'b10);
        chk("t3_pulses", 2'(chgCount), 2'd1);

        // tick cadence over four periods
        begin
            int tickCount;
            tickCount = 0;
            for (int i = 0; i < 4 * TDIV; i++) begin
                step();
                if (tick === 1'b1) tickCount++;
            end
            chk("t4_ticks", 2'(tickCount), 2'd0);
            chk("t4_ticks_hi", 2'(tickCount >> 2), 2'd1);
        end

`ifdef LIGHT_MODE_TICK_ALIGN_EN
        // debounce completes a few cycles ahead of the tick: commit lands on the tick cycle
        chgCount = 0;
        while (mN % TDIV != 7) step();
        swRaw = 2'b11;
        repeat (14) step();
        chk("t5_mode", mode, 2'b11);
        chk("t5_pulses", 2'(chgCount), 2'd1);

        // revert while waiting for the tick: no commit
        chgCount = 0;
        while (mN % TDIV != 3) step();
        swRaw = 2'b01;
        repeat (7) step();
        chk("t5_pend", dbgState, PEND);
        swRaw = 2'b11;
        repeat (12) step();
        chk("t5_revert_mode", mode, 2'b11);
        chk("t5_revert_pulses", 2'(chgCount), 2'd0);
        chk("t5_revert_state", dbgState, IDLE);
`endif

        // reset in the middle of a debounce with dbCnt at 2
        chgCount = 0;
        swRaw = 2'b01;
        repeat (5) step();
        chk("t6_check", dbgState, CHECK);
        pulseReset();
        chk("t6_pulses", 2'(chgCount), 2'd0);
        repeat (16) step();
        chk("t6_mode", mode, 2'b01);

        // randomized switch activity with occasional resets
        for (int seg = 0; seg < 60; seg++) begin
            swRaw = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 8)) step();
            if ($urandom_range(0, 19) == 0) pulseReset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
